// File: rtl/key_bank.sv
// key_bank: key register bank behind the key generator.
//
// Captures n/e/d keys on their single-cycle valid ticks, tracks whether all three
// keys belong to the current generator session, and streams a selected key out as
// four big-endian bytes over a valid/ready handshake.
//
// Optional feature: define KEY_BANK_PROTO_CHECK_EN to enable protocol checking.
// When it is enabled, an e/d tick without a held n key, or an e tick without a
// matching d tick (or a d tick without a matching e tick), sets the sticky proto_err
// flag and discards the e/d capture. When it is not defined, proto_err is tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   gen_busy                 generator busy level; a rising edge opens a new session
//   n/e/d_key, *_key_valid   key values and their capture ticks
//   rd_start, rd_sel         readout request and key select (0=n, 1=e, 2=d; 3 ignored)
//   byte_ready               downstream accepts byte_out
//   n/e/d_out                stored keys
//   keys_ready               all three keys captured in the current session
//   byte_out, byte_valid     readout byte stream
//   rd_busy, rd_done         readout in progress / one-cycle completion tick
//   proto_err                sticky protocol-violation flag
`timescale 1ns/1ps

module key_bank (
    input  logic        clk,
    input  logic        rst,
    input  logic        gen_busy,
    input  logic [31:0] n_key,
    input  logic [31:0] e_key,
    input  logic [31:0] d_key,
    input  logic        n_key_valid,
    input  logic        e_key_valid,
    input  logic        d_key_valid,
    input  logic        rd_start,
    input  logic [1:0]  rd_sel,
    input  logic        byte_ready,
    output logic [31:0] n_out,
    output logic [31:0] e_out,
    output logic [31:0] d_out,
    output logic        keys_ready,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        proto_err
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e      state_q;
    logic        gen_busy_q;
    logic        n_have_q, e_have_q, d_have_q;
    logic [31:0] shift_q;
    logic [1:0]  idx_q;
    logic [31:0] sel_key;
    logic        session_open;
    logic        n_cap, e_cap, d_cap;

    assign session_open = gen_busy & ~gen_busy_q;
    assign n_cap        = n_key_valid;

`ifdef KEY_BANK_PROTO_CHECK_EN
    logic n_have_eff;
    logic err_now;

    // A session opening this cycle means no n key is held for checking purposes.
    assign n_have_eff = n_have_q & ~session_open;
    assign err_now    = ((e_key_valid | d_key_valid) & ~n_have_eff) |
                        (e_key_valid ^ d_key_valid);
    assign e_cap      = e_key_valid & ~err_now;
    assign d_cap      = d_key_valid & ~err_now;

    // Setting wins over a same-cycle session clear so the violation is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (err_now) begin
            proto_err <= 1'b1;
        end else if (session_open) begin
            proto_err <= 1'b0;
        end
    end
`else
    assign e_cap     = e_key_valid;
    assign d_cap     = d_key_valid;
    assign proto_err = 1'b0;
`endif

    // Key registers and session flags; capture is assigned last so it wins the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_busy_q <= 1'b0;
            n_have_q   <= 1'b0;
            e_have_q   <= 1'b0;
            d_have_q   <= 1'b0;
            n_out      <= 32'd0;
            e_out      <= 32'd0;
            d_out      <= 32'd0;
        end else begin
            gen_busy_q <= gen_busy;
            if (session_open) begin
                n_have_q <= 1'b0;
                e_have_q <= 1'b0;
                d_have_q <= 1'b0;
            end
            if (n_cap) begin
                n_out    <= n_key;
                n_have_q <= 1'b1;
            end
            if (e_cap) begin
                e_out    <= e_key;
                e_have_q <= 1'b1;
            end
            if (d_cap) begin
                d_out    <= d_key;
                d_have_q <= 1'b1;
            end
        end
    end

    assign keys_ready = n_have_q & e_have_q & d_have_q;

    always_comb begin
        sel_key = 32'd0;
        case (rd_sel)
            2'd0:    sel_key = n_out;
            2'd1:    sel_key = e_out;
            2'd2:    sel_key = d_out;
            default: sel_key = 32'd0;
        endcase
    end

    // Readout FSM. The stream runs from a snapshot, so key updates or a new
    // session during SEND do not disturb bytes already committed to.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shift_q    <= 32'd0;
            idx_q      <= 2'd0;
            byte_valid <= 1'b0;
            rd_busy    <= 1'b0;
            rd_done    <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rd_start && keys_ready && (rd_sel != 2'd3)) begin
                        state_q    <= StSend;
                        shift_q    <= sel_key;
                        idx_q      <= 2'd0;
                        byte_valid <= 1'b1;
                        rd_busy    <= 1'b1;
                    end
                end
                StSend: begin
                    if (byte_ready) begin
                        shift_q <= {shift_q[23:0], 8'd0};
                        idx_q   <= idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_q    <= StIdle;
                            byte_valid <= 1'b0;
                            rd_busy    <= 1'b0;
                            rd_done    <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign byte_out = shift_q[31:24];

endmodule

// File: tb/tb_key_bank.sv
`timescale 1ns/1ps

module tb_key_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        gen_busy;
    logic [31:0] n_key, e_key, d_key;
    logic        n_key_valid, e_key_valid, d_key_valid;
    logic        rd_start;
    logic [1:0]  rd_sel;
    logic        byte_ready;
    logic [31:0] n_out, e_out, d_out;
    logic        keys_ready;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        rd_busy;
    logic        rd_done;
    logic        proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_bank dut (
        .clk         (clk),
        .rst         (rst),
        .gen_busy    (gen_busy),
        .n_key       (n_key),
        .e_key       (e_key),
        .d_key       (d_key),
        .n_key_valid (n_key_valid),
        .e_key_valid (e_key_valid),
        .d_key_valid (d_key_valid),
        .rd_start    (rd_start),
        .rd_sel      (rd_sel),
        .byte_ready  (byte_ready),
        .n_out       (n_out),
        .e_out       (e_out),
        .d_out       (d_out),
        .keys_ready  (keys_ready),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .rd_busy     (rd_busy),
        .rd_done     (rd_done),
        .proto_err   (proto_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_session();
        gen_busy = 1'b0;
        tick();
        gen_busy = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b0; gen_busy = 1'b0;
        n_key = '0; e_key = '0; d_key = '0;
        n_key_valid = 1'b0; e_key_valid = 1'b0; d_key_valid = 1'b0;
        rd_start = 1'b0; rd_sel = 2'd0; byte_ready = 1'b0;

        // Reset held for 3 cycles
        tick(); tick(); tick();
        check("rst_n_out", n_out, 32'd0);
        check("rst_keys_ready", {31'd0, keys_ready}, 32'd0);
        check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_rd_busy", {31'd0, rd_busy}, 32'd0);
        check("rst_rd_done", {31'd0, rd_done}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_byte_out", {24'd0, byte_out}, 32'd0);
        rst = 1'b1;

        // rd_start with no keys is ignored
        rd_start = 1'b1;
        tick();
        check("nokey_valid0", {31'd0, byte_valid}, 32'd0);
        tick();
        check("nokey_valid1", {31'd0, byte_valid}, 32'd0);
        check("nokey_busy", {31'd0, rd_busy}, 32'd0);
        rd_start = 1'b0;

        // Normal session
        gen_busy = 1'b1;
        tick();
        n_key = 32'h0000C2A1; n_key_valid = 1'b1;
        tick();
        n_key_valid = 1'b0;
        check("norm_n_out", n_out, 32'h0000C2A1);
        check("norm_kr_early", {31'd0, keys_ready}, 32'd0);
        tick(); tick(); tick(); tick(); tick();
        e_key = 32'h00000011; d_key = 32'h0000B3F1;
        e_key_valid = 1'b1; d_key_valid = 1'b1;
        tick();
        e_key_valid = 1'b0; d_key_valid = 1'b0;
        check("norm_e_out", e_out, 32'h00000011);
        check("norm_d_out", d_out, 32'h0000B3F1);
        check("norm_keys_ready", {31'd0, keys_ready}, 32'd1);
        check("norm_proto_err", {31'd0, proto_err}, 32'd0);

        // Readout of n with a 2-cycle stall on byte 1
        rd_sel = 2'd0; rd_start = 1'b1; byte_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        check("rd0_valid", {31'd0, byte_valid}, 32'd1);
        check("rd0_busy", {31'd0, rd_busy}, 32'd1);
        check("rd0_b0", {24'd0, byte_out}, 32'h00);
        byte_ready = 1'b1;
        tick();
        check("rd0_b1", {24'd0, byte_out}, 32'h00);
        byte_ready = 1'b0;
        tick();
        check("rd0_stall1_b", {24'd0, byte_out}, 32'h00);
        check("rd0_stall1_v", {31'd0, byte_valid}, 32'd1);
        tick();
        check("rd0_stall2_b", {24'd0, byte_out}, 32'h00);
        check("rd0_stall2_v", {31'd0, byte_valid}, 32'd1);
        check("rd0_stall_done", {31'd0, rd_done}, 32'd0);
        byte_ready = 1'b1;
        tick();
        check("rd0_b2", {24'd0, byte_out}, 32'hC2);
        tick();
        check("rd0_b3", {24'd0, byte_out}, 32'hA1);
        check("rd0_b3_done", {31'd0, rd_done}, 32'd0);
        tick();
        check("rd0_end_valid", {31'd0, byte_valid}, 32'd0);
        check("rd0_end_busy", {31'd0, rd_busy}, 32'd0);
        check("rd0_end_done", {31'd0, rd_done}, 32'd1);
        byte_ready = 1'b0;
        tick();
        check("rd0_done_once", {31'd0, rd_done}, 32'd0);

        // New session and new n key during a readout of d
        gen_busy = 1'b0;
        tick();
        rd_sel = 2'd2; rd_start = 1'b1; byte_ready = 1'b1;
        tick();
        rd_start = 1'b0;
        check("rd2_b0", {24'd0, byte_out}, 32'h00);
        gen_busy = 1'b1;
        tick();
        check("rd2_b1", {24'd0, byte_out}, 32'h00);
        check("rd2_kr_cleared", {31'd0, keys_ready}, 32'd0);
        n_key = 32'h12345678; n_key_valid = 1'b1;
        tick();
        n_key_valid = 1'b0;
        check("rd2_b2", {24'd0, byte_out}, 32'hB3);
        check("rd2_n_out", n_out, 32'h12345678);
        tick();
        check("rd2_b3", {24'd0, byte_out}, 32'hF1);
        check("rd2_b3_valid", {31'd0, byte_valid}, 32'd1);
        tick();
        check("rd2_done", {31'd0, rd_done}, 32'd1);
        check("rd2_keys_ready", {31'd0, keys_ready}, 32'd0);
        byte_ready = 1'b0;

        // e/d ticks in a fresh session with no n key
        open_session();
        e_key = 32'hAAAA5555; d_key = 32'h0F0F0F0F;
        e_key_valid = 1'b1; d_key_valid = 1'b1;
        tick();
        e_key_valid = 1'b0; d_key_valid = 1'b0;
`ifdef KEY_BANK_PROTO_CHECK_EN
        check("proto_err_set", {31'd0, proto_err}, 32'd1);
        check("proto_e_kept", e_out, 32'h00000011);
`else
        check("proto_err_off", {31'd0, proto_err}, 32'd0);
        check("proto_e_upd", e_out, 32'hAAAA5555);
`endif
        check("proto_kr", {31'd0, keys_ready}, 32'd0);

        // Recapture, then async reset during byte 2
        open_session();
        check("sess_proto_clr", {31'd0, proto_err}, 32'd0);
        n_key = 32'h01020304; n_key_valid = 1'b1;
        tick();
        n_key_valid = 1'b0;
        e_key = 32'h5; d_key = 32'h7;
        e_key_valid = 1'b1; d_key_valid = 1'b1;
        tick();
        e_key_valid = 1'b0; d_key_valid = 1'b0;
        check("rc_keys_ready", {31'd0, keys_ready}, 32'd1);
        rd_sel = 2'd0; rd_start = 1'b1;
        tick();
        rd_start = 1'b0; byte_ready = 1'b1;
        tick();
        tick();
        check("rc_b2", {24'd0, byte_out}, 32'h03);
        byte_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, byte_valid}, 32'd0);
        check("arst_busy", {31'd0, rd_busy}, 32'd0);
        check("arst_kr", {31'd0, keys_ready}, 32'd0);
        check("arst_n_out", n_out, 32'd0);
        gen_busy = 1'b0;
        tick();
        rst = 1'b1;

        // Recapture, then rd_sel=3 must not start a stream
        open_session();
        n_key = 32'hDEADBEEF; n_key_valid = 1'b1;
        tick();
        n_key_valid = 1'b0;
        e_key_valid = 1'b1; d_key_valid = 1'b1;
        tick();
        e_key_valid = 1'b0; d_key_valid = 1'b0;
        check("sel3_kr", {31'd0, keys_ready}, 32'd1);
        rd_sel = 2'd3; rd_start = 1'b1;
        tick();
        check("sel3_valid0", {31'd0, byte_valid}, 32'd0);
        tick();
        rd_start = 1'b0;
        check("sel3_valid1", {31'd0, byte_valid}, 32'd0);
        check("sel3_busy", {31'd0, rd_busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
